// File: rtl/difftest_pkg.sv
// Shared types for the difftest architectural event path.
//   arch_event_t : one trap event as buffered and emitted to the difftest sink
//   DROP_CNT_W   : width of the saturating dropped-event counter
package difftest_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] interrupt;
        logic [31:0] exception;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        nmi;
        logic        hvictl;
    } arch_event_t;

endpackage

// File: rtl/difftest_sync_fifo.sv
// Generic synchronous FIFO of arch_event_t, no write-to-read bypass.
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   push, push_data: write request and payload (ignored when full without a pop)
//   pop            : read request (ignored when empty)
//   head_c         : entry at the head, combinational from storage
//   occupancy      : registered entry count
//   full_c, empty_c: decoded from occupancy
module difftest_sync_fifo
    import difftest_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  arch_event_t              push_data,
    input  logic                     pop,
    output arch_event_t              head_c,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    arch_event_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full_c  = (occupancy == OCC_W'(DEPTH));
    assign empty_c = (occupancy == '0);
    assign pop_ok  = pop && !empty_c;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok = push && (!full_c || pop_ok);
    assign head_c  = mem[rd_ptr];

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/difftest_arch_event_queue.sv
// Buffers architectural trap events from the core and emits them one per cycle
// to the difftest arch-event sink when the step gate allows. The core is never
// back-pressured; events that find the queue full are dropped and counted.
//   clock, reset_n       : rising-edge clock, synchronous active-low reset
//   in_*                 : trap event from the commit/CSR stage
//   drain_en             : sink may accept one event this cycle
//   out_enable/out_valid : event emitted this cycle (identical)
//   out_*                : emitted event fields, held while idle
//   out_coreid           : constant CORE_ID
//   overflow, drop_count : sticky drop flag and saturating drop counter
//   occupancy            : current queue entry count
module difftest_arch_event_queue
    import difftest_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [7:0]  CORE_ID = 8'd0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [31:0]             in_interrupt,
    input  logic [31:0]             in_exception,
    input  logic [63:0]             in_pc,
    input  logic [31:0]             in_inst,
    input  logic                    in_nmi,
    input  logic                    in_hvictl,
    input  logic                    drain_en,
    output logic                    out_enable,
    output logic                    out_valid,
    output logic [31:0]             out_interrupt,
    output logic [31:0]             out_exception,
    output logic [63:0]             out_pc,
    output logic [31:0]             out_inst,
    output logic                    out_nmi,
    output logic                    out_hvictl,
    output logic [7:0]              out_coreid,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count,
    output logic [$clog2(DEPTH):0]  occupancy
);

    arch_event_t  evt_c;
    arch_event_t  head_c;
    arch_event_t  out_q;
    logic         live_c;
    logic         pop_c;
    logic         push_c;
    logic         drop_c;
    logic         full_c;
    logic         empty_c;

    // Qualify: a valid with no cause and no NMI carries nothing to report.
    assign live_c = in_valid && ((in_interrupt != '0) || (in_exception != '0) || in_nmi);

    // Normalise: interrupt wins over exception, except NMIs which are kept verbatim.
    always_comb begin
        evt_c.interrupt = in_interrupt;
        evt_c.exception = in_exception;
        evt_c.pc        = in_pc;
        evt_c.inst      = in_inst;
        evt_c.nmi       = in_nmi;
        evt_c.hvictl    = in_hvictl;
        if (!in_nmi && (in_interrupt != '0)) begin
            evt_c.exception = '0;
        end
    end

    // Pop decision uses registered occupancy, so a same-cycle push into an
    // empty queue is not visible until the next cycle.
    assign pop_c  = drain_en && !empty_c;
    assign push_c = live_c && (!full_c || pop_c);
    assign drop_c = live_c && !push_c;

    difftest_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (evt_c),
        .pop       (pop_c),
        .head_c    (head_c),
        .occupancy (occupancy),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Output register and drop status.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_enable <= 1'b0;
            out_q      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            out_enable <= pop_c;
            if (pop_c) begin
                out_q <= head_c;
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign out_valid     = out_enable;
    assign out_interrupt = out_q.interrupt;
    assign out_exception = out_q.exception;
    assign out_pc        = out_q.pc;
    assign out_inst      = out_q.inst;
    assign out_nmi       = out_q.nmi;
    assign out_hvictl    = out_q.hvictl;
    assign out_coreid    = CORE_ID;

endmodule

// File: tb/tb_difftest_arch_event_queue.sv
// Scoreboard bench for difftest_arch_event_queue: stimulus pushes expected
// emitted events into a queue, a negedge monitor pops and compares them.
module tb_difftest_arch_event_queue;
    import difftest_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam logic [7:0]  CORE_ID = 8'h5A;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_interrupt;
    logic [31:0] in_exception;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        in_nmi;
    logic        in_hvictl;
    logic        drain_en;
    logic        out_enable;
    logic        out_valid;
    logic [31:0] out_interrupt;
    logic [31:0] out_exception;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_nmi;
    logic        out_hvictl;
    logic [7:0]  out_coreid;
    logic        overflow;
    logic [15:0] drop_count;
    logic [2:0]  occupancy;

    arch_event_t exp_q[$];
    arch_event_t mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    difftest_arch_event_queue #(
        .DEPTH   (DEPTH),
        .CORE_ID (CORE_ID)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_interrupt  (in_interrupt),
        .in_exception  (in_exception),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_nmi        (in_nmi),
        .in_hvictl     (in_hvictl),
        .drain_en      (drain_en),
        .out_enable    (out_enable),
        .out_valid     (out_valid),
        .out_interrupt (out_interrupt),
        .out_exception (out_exception),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_nmi       (out_nmi),
        .out_hvictl    (out_hvictl),
        .out_coreid    (out_coreid),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .occupancy     (occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every emitted event must match the oldest expected one.
    always @(negedge clock) begin
        chk("valid_eq_enable", 64'(out_valid), 64'(out_enable));
        if (out_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_emit: got event pc=0x%0h, expected no event", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("emit_interrupt", 64'(out_interrupt), 64'(mon_e.interrupt));
                chk("emit_exception", 64'(out_exception), 64'(mon_e.exception));
                chk("emit_pc",        out_pc,             mon_e.pc);
                chk("emit_inst",      64'(out_inst),      64'(mon_e.inst));
                chk("emit_nmi",       64'(out_nmi),       64'(mon_e.nmi));
                chk("emit_hvictl",    64'(out_hvictl),    64'(mon_e.hvictl));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive one event for one cycle; if accepted, record the hand-computed result.
    task automatic send(input logic [31:0] i, input logic [31:0] x, input logic [63:0] pc,
                        input logic [31:0] ins, input logic nmi, input logic hv,
                        input bit accept, input logic [31:0] exp_x);
        arch_event_t e;
        in_valid     = 1'b1;
        in_interrupt = i;
        in_exception = x;
        in_pc        = pc;
        in_inst      = ins;
        in_nmi       = nmi;
        in_hvictl    = hv;
        if (accept) begin
            e.interrupt = i;
            e.exception = exp_x;
            e.pc        = pc;
            e.inst      = ins;
            e.nmi       = nmi;
            e.hvictl    = hv;
            exp_q.push_back(e);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain_all(input int budget);
        int n;
        n = 0;
        drain_en = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending events after %0d cycles, expected 0",
                     exp_q.size(), n);
        end
        repeat (2) cyc();
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_interrupt = '0;
        in_exception = '0;
        in_pc        = '0;
        in_inst      = '0;
        in_nmi       = 1'b0;
        in_hvictl    = 1'b0;
        drain_en     = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;

        // Reset state
        chk("rst_occupancy",  64'(occupancy),  0);
        chk("rst_out_enable", 64'(out_enable), 0);
        chk("rst_overflow",   64'(overflow),   0);
        chk("rst_drop_count", 64'(drop_count), 0);
        chk("rst_out_pc",     out_pc,          0);
        chk("coreid",         64'(out_coreid), 64'h5A);

        // Single event: 2-cycle latency, one-cycle pulse, data held afterwards
        drain_en = 1'b1;
        send(32'd7, 32'd0, 64'h8000_0010, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'd0);
        chk("single_n1_enable",    64'(out_enable), 0);
        chk("single_n1_occupancy", 64'(occupancy),  1);
        cyc();
        chk("single_n2_enable",    64'(out_enable), 1);
        chk("single_n2_interrupt", 64'(out_interrupt), 7);
        cyc();
        chk("single_n3_enable",    64'(out_enable), 0);
        chk("single_hold_pc",      out_pc,          64'h8000_0010);

        // Priority, NMI kept verbatim, non-live ignored
        send(32'd3, 32'd2, 64'h8000_0100, 32'h0010_0073, 1'b0, 1'b1, 1'b1, 32'd0);
        send(32'd5, 32'd9, 64'h8000_0200, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'd9);
        send(32'd0, 32'd0, 64'h8000_0300, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'd0);
        send(32'd0, 32'd0, 64'h8000_0400, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'd0);
        drain_all(10);
        chk("nonlive_drop_count", 64'(drop_count), 0);
        chk("nonlive_overflow",   64'(overflow),   0);
        chk("nonlive_occupancy",  64'(occupancy),  0);

        // Overflow: 6 pushes into 4 entries without draining
        drain_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(32'd0, 32'(k + 1), 64'h9000_0000 + 64'(k * 4), 32'h100 + 32'(k),
                 1'b0, 1'b0, k < 4, 32'(k + 1));
        end
        chk("ovf_occupancy",  64'(occupancy),  4);
        chk("ovf_overflow",   64'(overflow),   1);
        chk("ovf_drop_count", 64'(drop_count), 2);

        // Full FIFO with simultaneous pop and push: accepted, occupancy unchanged
        drain_en = 1'b1;
        send(32'd11, 32'd0, 64'h9000_0100, 32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'd0);
        chk("fullpp_occupancy",  64'(occupancy),  4);
        chk("fullpp_drop_count", 64'(drop_count), 2);
        chk("burst_enable_0",    64'(out_enable), 1);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("burst_enable", 64'(out_enable), 1);
        end
        cyc();
        chk("burst_end_enable",    64'(out_enable), 0);
        chk("burst_end_occupancy", 64'(occupancy),  0);

        // Wrap-around: interleaved push/pop over 10 events
        for (int k = 0; k < 10; k++) begin
            drain_en = 1'b0;
            if (k % 2 == 0)
                send(32'd0, 32'(k + 1), 64'hA000_0000 + 64'(k * 8), 32'h300 + 32'(k),
                     1'b0, k[1], 1'b1, 32'(k + 1));
            else
                send(32'(k), 32'h20, 64'hA000_0000 + 64'(k * 8), 32'h300 + 32'(k),
                     1'b0, k[1], 1'b1, 32'd0);
            drain_en = 1'b1;
            cyc();
        end
        drain_all(20);
        chk("wrap_drop_count", 64'(drop_count), 2);

        // Reset mid-operation: 4 queued + overflow, pop and reset in the same cycle
        drain_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(32'd1, 32'd0, 64'hB000_0000 + 64'(k * 4), 32'h400 + 32'(k),
                 1'b0, 1'b0, 1'b0, 32'd0);
        end
        chk("pre_rst_occupancy",  64'(occupancy),  4);
        chk("pre_rst_drop_count", 64'(drop_count), 3);
        drain_en = 1'b1;
        reset_n  = 1'b0;
        cyc();
        reset_n  = 1'b1;
        chk("mid_rst_out_enable", 64'(out_enable), 0);
        chk("mid_rst_occupancy",  64'(occupancy),  0);
        chk("mid_rst_overflow",   64'(overflow),   0);
        chk("mid_rst_drop_count", 64'(drop_count), 0);
        chk("mid_rst_out_pc",     out_pc,          0);
        repeat (6) cyc();
        chk("post_rst_occupancy", 64'(occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/difftest_arch_event_queue.md
# difftest_arch_event_queue

Buffers architectural trap events (interrupts, exceptions, NMIs) from the core's commit/CSR stage and presents them one per cycle to the difftest arch-event sink. Sits between the core trap logic and the difftest ArchEvent DPI wrapper. The sink's `enable`/`io_valid` only fire when the difftest step gate (`drain_en`) allows. The core cannot be back-pressured: on overflow, events are dropped and counted.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CORE_ID`, default 0: 8-bit constant driven on `out_coreid`.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  trap event presented this cycle.
- `in_interrupt`  in  32  interrupt cause; 0 means none.
- `in_exception`  in  32  exception cause; 0 means none.
- `in_pc`  in  64  trapping PC.
- `in_inst`  in  32  trapping instruction bits.
- `in_nmi`  in  1  event is an NMI.
- `in_hvictl`  in  1  virtual interrupt injected via hvictl.
- `drain_en`  in  1  sink may accept one event this cycle.
- `out_enable`, `out_valid`  out  1  event emitted; always equal.
- `out_interrupt`, `out_exception`  out  32 each.
- `out_pc`  out  64.
- `out_inst`  out  32.
- `out_nmi`, `out_hvictl`  out  1 each.
- `out_coreid`  out  8  constant `CORE_ID`.
- `overflow`  out  1  sticky; set on the first dropped event.
- `drop_count`  out  16  dropped events; saturates at 0xFFFF.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.

## Operation
- **Qualify.** An event is live when `in_valid && (in_interrupt!=0 || in_exception!=0 || in_nmi)`. A non-live `in_valid` is ignored silently and not counted.
- **Normalise.** If both cause fields are nonzero, the interrupt wins: the stored `exception` is 0. If `in_nmi=1`, the event is stored as-is.
- **Push.** A live event is written at the tail unless the FIFO is full and no pop occurs this cycle. Otherwise the event is dropped: `overflow` is set to 1 and `drop_count` is incremented, saturating.
- **Pop.** When `drain_en && occupancy!=0`, the head entry is read and occupancy decrements. The popped entry is registered into the `out_*` fields, and `out_enable` is 1 for exactly the next cycle.
- **Idle outputs.** When `out_enable=0`, the `out_*` data fields hold their last value; only `out_enable`/`out_valid` drop.
- **Simultaneous push and pop.**
  - Full FIFO: the push is accepted and occupancy is unchanged.
  - Empty FIFO: no bypass. The pop is not taken, and the pushed entry is not eligible until the next cycle.
- **Wrap-around.** Head and tail pointers wrap modulo `DEPTH`. Full/empty are determined from `occupancy`.
- **Ordering.** Strictly FIFO; events are never reordered or merged.

## Timing
- **Reset** (`reset_n=0` at a clock edge):
  - occupancy, pointers, `out_enable`, `out_valid`, all `out_*` data fields, `overflow` and `drop_count` all become 0.
  - `out_coreid` is `CORE_ID` at all times.
  - Reset asserted mid-operation discards all buffered events, including one already popped but not yet emitted.
- **Latency.**
  - A live event at cycle N enters the FIFO at the end of N.
  - With `drain_en=1` at N+1, it pops at N+1 and `out_enable=1` in cycle N+2.
  - Minimum latency is therefore 2 cycles.
- **Throughput.** One emitted event per cycle while `drain_en` is held and the FIFO is non-empty.
- **Status timing.** `overflow` and `drop_count` update at the end of the cycle in which the drop occurs.

## Structure
- Package `difftest_pkg` contains:
  - `arch_event_t`: packed struct {interrupt[31:0], exception[31:0], pc[63:0], inst[31:0], nmi, hvictl}, 162 bits.
  - `DROP_CNT_W = 16`.
- Sub-module `difftest_sync_fifo`: a generic `arch_event_t` FIFO with push/pop/occupancy and no bypass.
- The top level holds the qualify/normalise logic, the drop counter and the output register.

## Test plan
- **Single event.** Reset, then drive `in_interrupt=7, in_pc=0x8000_0010` for 1 cycle with `drain_en=1` → `out_enable=1` exactly 2 cycles later with `out_interrupt=7, out_exception=0, out_pc=0x8000_0010`, then 0.
- **Priority.** Drive `in_interrupt=3, in_exception=2` → emitted `out_interrupt=3, out_exception=0`. Drive `in_valid=1` with both causes 0 and `nmi=0` → nothing emitted, `drop_count` unchanged.
- **Overflow.** With `drain_en=0`, push 6 live events, DEPTH=4 → `occupancy=4`, `overflow=1`, `drop_count=2`. Then raise `drain_en` → the first 4 events are emitted in order on 4 consecutive cycles.
- **Full with simultaneous push and pop.** Full FIFO, `drain_en=1` plus a push → push accepted, `occupancy` stays 4, `drop_count` unchanged.
- **Wrap-around.** Push/pop 10 events interleaved, with the pointers wrapping twice → sequence emitted in order with no loss.
- **Reset mid-operation.** 3 entries queued plus one popped, then `reset_n=0` for 1 cycle → `out_enable=0` on the following cycle, `occupancy=0`, `overflow=0`, `drop_count=0`, and no further events emitted.
